// File: rtl/piso_tx_pkg.sv
// Shared types and defaults for the parallel-in serial-out transmitter.
// The state encoding is exported so checkers can decode the debug state bus.
package piso_tx_pkg;

  localparam int DEFAULT_DATA_WIDTH   = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int width_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Per-bit cycle counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle.
// wrap is high during the final cycle of a bit, so the owner advances on that edge.
module bit_timer
  import piso_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic wrap
);

  localparam int            TW   = width_for(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign wrap = (cnt == LAST);

endmodule

// File: rtl/piso_tx.sv
// Frames a parallel word as start bit, LSB-first data bits and stop bit on an
// idle-high serial line; each bit lasts CLKS_PER_BIT clock cycles.
//
// Handshake: LOAD is a request sampled on a rising edge; it is accepted only
// when the FSM is in IDLE (BUSY low, including the DONE cycle) and is silently
// dropped otherwise. There is no backpressure beyond BUSY.
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  LOAD,
  input  logic [DATA_WIDTH-1:0] DATA,
  output logic                  SERIAL_OUT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [1:0]            dbg_state
);

  localparam int            IW       = width_for(DATA_WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [IW-1:0]         idx;
  logic                  timer_clear;
  logic                  wrap;

  // Holding the timer at zero throughout IDLE means the accept edge always
  // starts the START bit with a fresh count.
  assign timer_clear = (state == S_IDLE);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(timer_clear),
    .wrap (wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      shreg      <= '0;
      idx        <= '0;
      SERIAL_OUT <= 1'b1;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          SERIAL_OUT <= 1'b1;
          BUSY       <= 1'b0;
          if (LOAD) begin
            state      <= S_START;
            shreg      <= DATA;
            idx        <= '0;
            SERIAL_OUT <= 1'b0;
            BUSY       <= 1'b1;
          end
        end
        S_START: begin
          if (wrap) begin
            state      <= S_DATA;
            SERIAL_OUT <= shreg[0];
            shreg      <= shreg >> 1;
          end
        end
        S_DATA: begin
          if (wrap) begin
            if (idx == LAST_IDX) begin
              state      <= S_STOP;
              SERIAL_OUT <= 1'b1;
            end else begin
              idx        <= idx + 1'b1;
              SERIAL_OUT <= shreg[0];
              shreg      <= shreg >> 1;
            end
          end
        end
        S_STOP: begin
          if (wrap) begin
            state      <= S_IDLE;
            SERIAL_OUT <= 1'b1;
            BUSY       <= 1'b0;
            DONE       <= 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          SERIAL_OUT <= 1'b1;
          BUSY       <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: one instance at 4 clocks/bit, one at 1 clock/bit.
// Outputs are sampled 1 time unit after each rising edge.
module tb_piso_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_a, load_b;
  logic [7:0] data_a, data_b;
  logic       ser_a, busy_a, done_a;
  logic       ser_b, busy_b, done_b;
  logic [1:0] st_a, st_b;

  int n_checks = 0;
  int n_errors = 0;

  logic [0:0] exp_q[$];

  always #5 clk = ~clk;

  piso_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut_a (
    .clk(clk), .rst(rst), .LOAD(load_a), .DATA(data_a),
    .SERIAL_OUT(ser_a), .BUSY(busy_a), .DONE(done_a), .dbg_state(st_a)
  );

  piso_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut_b (
    .clk(clk), .rst(rst), .LOAD(load_b), .DATA(data_b),
    .SERIAL_OUT(ser_b), .BUSY(busy_b), .DONE(done_b), .dbg_state(st_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level per cycle: start 0, data LSB first, stop 1.
  task automatic push_frame(input logic [7:0] d, input int cpb);
    logic [9:0] bits;
    bits = {1'b1, d, 1'b0};
    for (int i = 0; i < 10; i++)
      for (int k = 0; k < cpb; k++)
        exp_q.push_back(bits[i]);
  endtask

  // Drives LOAD with d for the next edge (edge 0) and checks cycles 1..41.
  // ld_cyc > 0 raises LOAD with ld_data during that cycle of the frame.
  // With chain set, returns in the DONE cycle so the caller can load again.
  task automatic run_frame_a(input logic [7:0] d, input int ld_cyc,
                             input logic [7:0] ld_data, input bit chain);
    logic [0:0] e;
    push_frame(d, 4);
    load_a = 1'b1;
    data_a = d;
    tick();
    load_a = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      e = exp_q.pop_front();
      check($sformatf("a_ser_%0h_c%0d", d, c), ser_a, e);
      check($sformatf("a_busy_%0h_c%0d", d, c), busy_a, 1);
      check($sformatf("a_done_%0h_c%0d", d, c), done_a, 0);
      if (c == ld_cyc) begin
        load_a = 1'b1;
        data_a = ld_data;
      end else begin
        load_a = 1'b0;
      end
      tick();
    end
    check($sformatf("a_done41_%0h", d), done_a, 1);
    check($sformatf("a_busy41_%0h", d), busy_a, 0);
    check($sformatf("a_ser41_%0h", d), ser_a, 1);
    check($sformatf("a_state41_%0h", d), st_a, 0);
    if (!chain) begin
      for (int c = 42; c <= 47; c++) begin
        tick();
        check($sformatf("a_idle_ser_%0h_c%0d", d, c), ser_a, 1);
        check($sformatf("a_idle_busy_%0h_c%0d", d, c), busy_a, 0);
        check($sformatf("a_idle_done_%0h_c%0d", d, c), done_a, 0);
      end
    end
  endtask

  initial begin
    logic [9:0] bits81;
    logic [0:0] e;
    int done_seen;

    rst = 1'b1; load_a = 1'b0; load_b = 1'b0; data_a = '0; data_b = '0;
    tick();
    tick();
    check("rst_ser_a", ser_a, 1);
    check("rst_busy_a", busy_a, 0);
    check("rst_done_a", done_a, 0);
    check("rst_state_a", st_a, 0);
    check("rst_ser_b", ser_b, 1);
    check("rst_busy_b", busy_b, 0);
    rst = 1'b0;
    tick();

    // Plain A5 frame, then A5 with an ignored LOAD of 3C mid-frame.
    run_frame_a(8'hA5, 0, 8'h00, 1'b0);
    run_frame_a(8'hA5, 10, 8'h3C, 1'b0);

    // Back-to-back: FF loaded in the DONE cycle of an A5 frame.
    run_frame_a(8'hA5, 0, 8'h00, 1'b1);
    run_frame_a(8'hFF, 0, 8'h00, 1'b0);

    // Reset during cycle 20 of an 81 frame.
    bits81 = {1'b1, 8'h81, 1'b0};
    load_a = 1'b1;
    data_a = 8'h81;
    tick();
    load_a = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      check($sformatf("r_ser_c%0d", c), ser_a, bits81[(c-1)/4]);
      check($sformatf("r_busy_c%0d", c), busy_a, 1);
      if (c == 20) rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    check("r_ser_after", ser_a, 1);
    check("r_busy_after", busy_a, 0);
    check("r_state_after", st_a, 0);
    done_seen = (done_a === 1'b1) ? 1 : 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (done_a !== 1'b0) done_seen++;
    end
    check("r_no_done", done_seen, 0);
    check("r_ser_idle", ser_a, 1);

    // Reset and LOAD on the same edge.
    rst = 1'b1;
    load_a = 1'b1;
    data_a = 8'h5A;
    tick();
    check("rl_ser", ser_a, 1);
    check("rl_busy", busy_a, 0);
    check("rl_state", st_a, 0);
    rst = 1'b0;
    load_a = 1'b0;
    tick();
    check("rl_ser2", ser_a, 1);
    check("rl_busy2", busy_a, 0);
    check("rl_state2", st_a, 0);
    check("rl_done2", done_a, 0);

    // One clock per bit, DATA=01.
    push_frame(8'h01, 1);
    load_b = 1'b1;
    data_b = 8'h01;
    tick();
    load_b = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      e = exp_q.pop_front();
      check($sformatf("b_ser_c%0d", c), ser_b, e);
      check($sformatf("b_busy_c%0d", c), busy_b, 1);
      check($sformatf("b_done_c%0d", c), done_b, 0);
      tick();
    end
    check("b_done11", done_b, 1);
    check("b_busy11", busy_b, 0);
    check("b_ser11", ser_b, 1);
    tick();
    check("b_done12", done_b, 0);
    check("b_ser12", ser_b, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
